// File: rtl/divlut_ctrl.sv
// ---------------------------------------------------------------------------
// divlut_ctrl
//
// Sequencer and read arbiter for the divide lookup table.
//   * Loads the table from a configuration word stream.
//   * Drives the table's run input, including the write-address flush pulse.
//   * In run mode, shares the single read port between two requesters
//     with round-robin arbitration.
//   * Regenerates read-valid timing for the table's 1-cycle read latency.
//
// Ports
//   clk, reset           clock, asynchronous active-high reset
//   cfg_data/valid/ready load word stream (accepted on cfg_valid & cfg_ready)
//   cfg_reload           pulse: discard table and restart the load
//   loaded, load_count   load status
//   req0/1, addr0/1      read requests (held until granted)
//   gnt0/1               combinational grants
//   rsp0/1_valid         registered read-valid, one cycle after the grant
//   rsp_data             shared read data, passthrough of lut_rd_data
//   lut_*                table control and data interface
// ---------------------------------------------------------------------------
module divlut_ctrl #(
    parameter int AW = 11,
    parameter int DW = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] cfg_data,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic          cfg_reload,
    output logic          loaded,
    output logic [AW:0]   load_count,
    input  logic          req0,
    input  logic          req1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rsp0_valid,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp_data,
    output logic          lut_run,
    output logic [DW-1:0] lut_wr_data,
    output logic          lut_wr_en,
    output logic [AW-1:0] lut_rd_addr,
    output logic          lut_rd_en,
    input  logic [DW-1:0] lut_rd_data
);

    // Index of the last word of a full table load (2**AW - 1).
    localparam logic [AW:0] LAST_WORD = {1'b0, {AW{1'b1}}};

    typedef enum logic [1:0] {
        ST_FLUSH = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_lut_run;
    logic          r_loaded;
    logic [AW:0]   r_load_count;
    logic          r_rr_ptr;
    logic          r_rsp0_valid;
    logic          r_rsp1_valid;

    logic          w_in_load;
    logic          w_in_run;
    logic          w_cfg_ready;
    logic          w_accept;
    logic          w_last_word;
    logic          w_arb_en;
    logic          w_gnt0;
    logic          w_gnt1;

    assign w_in_load   = (r_state == ST_LOAD);
    assign w_in_run    = (r_state == ST_RUN);

    // A reload cycle never accepts a word and never grants a read.
    assign w_cfg_ready = w_in_load & ~cfg_reload;
    assign w_accept    = w_cfg_ready & cfg_valid;
    assign w_last_word = (r_load_count == LAST_WORD);
    assign w_arb_en    = w_in_run & ~cfg_reload;

    // Round-robin: r_rr_ptr names the requester that wins a tie.
    assign w_gnt0 = w_arb_en & req0 & (~req1 | ~r_rr_ptr);
    assign w_gnt1 = w_arb_en & req1 & (~req0 |  r_rr_ptr);

    assign cfg_ready   = w_cfg_ready;
    assign loaded      = r_loaded;
    assign load_count  = r_load_count;
    assign gnt0        = w_gnt0;
    assign gnt1        = w_gnt1;
    assign rsp0_valid  = r_rsp0_valid;
    assign rsp1_valid  = r_rsp1_valid;
    assign rsp_data    = lut_rd_data;
    assign lut_run     = r_lut_run;
    assign lut_wr_data = cfg_data;
    assign lut_wr_en   = w_accept;
    assign lut_rd_en   = w_gnt0 | w_gnt1;
    assign lut_rd_addr = w_gnt1 ? addr1 : addr0;

    // Load/run sequencer with registered run, loaded and word count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_FLUSH;
            r_lut_run    <= 1'b0;
            r_loaded     <= 1'b0;
            r_load_count <= '0;
        end else begin
            case (r_state)
                ST_FLUSH: begin
                    // Out of reset lut_run is still low, so the first FLUSH
                    // cycle arms the pulse; the pulsed cycle moves on to LOAD.
                    // Reload is ignored here.
                    r_loaded     <= 1'b0;
                    r_load_count <= '0;
                    if (r_lut_run) begin
                        r_state   <= ST_LOAD;
                        r_lut_run <= 1'b0;
                    end else begin
                        r_state   <= ST_FLUSH;
                        r_lut_run <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (cfg_reload) begin
                        r_state      <= ST_FLUSH;
                        r_lut_run    <= 1'b1;
                        r_loaded     <= 1'b0;
                        r_load_count <= '0;
                    end else if (w_accept) begin
                        r_load_count <= r_load_count + {{AW{1'b0}}, 1'b1};
                        if (w_last_word) begin
                            r_state   <= ST_RUN;
                            r_lut_run <= 1'b1;
                            r_loaded  <= 1'b1;
                        end else begin
                            r_state   <= ST_LOAD;
                            r_lut_run <= 1'b0;
                        end
                    end else begin
                        r_state   <= ST_LOAD;
                        r_lut_run <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (cfg_reload) begin
                        r_state      <= ST_FLUSH;
                        r_lut_run    <= 1'b1;
                        r_loaded     <= 1'b0;
                        r_load_count <= '0;
                    end else begin
                        // Count stays saturated at the table depth.
                        r_state   <= ST_RUN;
                        r_lut_run <= 1'b1;
                        r_loaded  <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= ST_FLUSH;
                    r_lut_run    <= 1'b0;
                    r_loaded     <= 1'b0;
                    r_load_count <= '0;
                end
            endcase
        end
    end

    // Round-robin pointer update and read-valid regeneration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr     <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
        end else begin
            r_rsp0_valid <= w_gnt0;
            r_rsp1_valid <= w_gnt1;
            if (w_gnt0) begin
                r_rr_ptr <= 1'b1;
            end else if (w_gnt1) begin
                r_rr_ptr <= 1'b0;
            end else begin
                r_rr_ptr <= r_rr_ptr;
            end
        end
    end

endmodule

// File: tb/tb_divlut_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for divlut_ctrl. A behavioural table stands in for the real
// lookup table; a reference model holds the words streamed since the last
// flush and the round-robin preference. Grants are checked in the cycle
// they are issued and the expected response is queued; a separate monitor
// pops and compares whenever a response valid is seen.
// ---------------------------------------------------------------------------
module tb_divlut_ctrl;

    localparam int AW    = 11;
    localparam int DW    = 11;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          reset;
    logic [DW-1:0] cfg_data;
    logic          cfg_valid;
    logic          cfg_ready;
    logic          cfg_reload;
    logic          loaded;
    logic [AW:0]   load_count;
    logic          req0, req1;
    logic [AW-1:0] addr0, addr1;
    logic          gnt0, gnt1;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp_data;
    logic          lut_run;
    logic [DW-1:0] lut_wr_data;
    logic          lut_wr_en;
    logic [AW-1:0] lut_rd_addr;
    logic          lut_rd_en;
    logic [DW-1:0] lut_rd_data;

    divlut_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_data   (cfg_data),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_reload (cfg_reload),
        .loaded     (loaded),
        .load_count (load_count),
        .req0       (req0),
        .req1       (req1),
        .addr0      (addr0),
        .addr1      (addr1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .rsp0_valid (rsp0_valid),
        .rsp1_valid (rsp1_valid),
        .rsp_data   (rsp_data),
        .lut_run    (lut_run),
        .lut_wr_data(lut_wr_data),
        .lut_wr_en  (lut_wr_en),
        .lut_rd_addr(lut_rd_addr),
        .lut_rd_en  (lut_rd_en),
        .lut_rd_data(lut_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural lookup table: run returns the write address to 0,
    // writes auto-increment, reads have one cycle of latency.
    logic [DW-1:0] tbl_mem [DEPTH];
    int            tbl_wptr = 0;
    always @(posedge clk) begin
        if (lut_run) begin
            tbl_wptr <= 0;
        end else if (lut_wr_en) begin
            tbl_mem[tbl_wptr % DEPTH] <= lut_wr_data;
            tbl_wptr <= tbl_wptr + 1;
        end
        if (lut_rd_en) lut_rd_data <= tbl_mem[lut_rd_addr];
    end

    // Reference model and scoreboard
    typedef struct { int id; int data; } exp_t;
    exp_t sb_q[$];
    int   ref_words[$];
    int   ref_prio;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response monitor: pops one expectation per observed response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (!reset && (rsp0_valid || rsp1_valid)) begin
                if (sb_q.size() == 0) begin
                    chk("rsp_unexpected", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("rsp_id", {30'd0, rsp1_valid, rsp0_valid}, (e.id == 0) ? 32'd1 : 32'd2);
                    chk("rsp_data", 32'(rsp_data), 32'(e.data));
                end
            end
        end
    end

    // Wait for the single run pulse of a flush, then check LOAD entry.
    task automatic expect_flush(input bit reload_in_flush);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            cfg_reload = (k == 0) ? reload_in_flush : 1'b0;
            cfg_valid  = 1'b1;
            cfg_data   = DW'($urandom);
            req0 = 1'b1; req1 = 1'b1;
            addr0 = AW'(1); addr1 = AW'(2);
            #1;
            chk("flush_cfg_ready", 32'(cfg_ready), 32'd0);
            chk("flush_wr_en", 32'(lut_wr_en), 32'd0);
            chk("flush_gnt", {30'd0, gnt1, gnt0}, 32'd0);
            seen = lut_run;
        end
        chk("flush_pulse_seen", 32'(seen), 32'd1);
        ref_words.delete();
        chk("flush_load_count", 32'(load_count), 32'd0);
        chk("flush_loaded", 32'(loaded), 32'd0);
        @(negedge clk);
        cfg_reload = 1'b0; cfg_valid = 1'b0; req0 = 1'b0; req1 = 1'b0;
        #1;
        chk("load_entry_run", 32'(lut_run), 32'd0);
        chk("load_entry_ready", 32'(cfg_ready), 32'd1);
        chk("load_entry_count", 32'(load_count), 32'd0);
    endtask

    // Stream n words (value = index or random) with random idle cycles.
    task automatic load_words(input int n, input bit use_index, input bit hold_req);
        int            i;
        bit            v;
        logic [DW-1:0] d;
        i = 0;
        while (i < n) begin
            @(negedge clk);
            v = ($urandom_range(0, 3) != 0);
            d = use_index ? DW'(i) : DW'($urandom);
            cfg_valid = v; cfg_data = d;
            req0 = hold_req; addr0 = AW'(3);
            req1 = hold_req ? 1'($urandom_range(0, 1)) : 1'b0; addr1 = AW'(4);
            #1;
            chk("load_count", 32'(load_count), 32'(ref_words.size()));
            chk("load_ready", 32'(cfg_ready), 32'd1);
            chk("load_run", 32'(lut_run), 32'd0);
            chk("load_loaded", 32'(loaded), 32'd0);
            chk("load_wr_en", 32'(lut_wr_en), 32'(v));
            chk("load_gnt", {30'd0, gnt1, gnt0}, 32'd0);
            chk("load_rd_en", 32'(lut_rd_en), 32'd0);
            if (v) begin
                chk("load_wr_data", 32'(lut_wr_data), 32'(d));
                ref_words.push_back(int'(d));
                i++;
            end
        end
    endtask

    // One RUN cycle: predict the grant, check it, queue the response.
    task automatic step_run(input logic r0, input logic r1,
                            input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                            output int g);
        bit cv;
        @(negedge clk);
        cv = 1'($urandom_range(0, 1));
        cfg_valid = cv; cfg_data = DW'($urandom); cfg_reload = 1'b0;
        req0 = r0; req1 = r1; addr0 = a0; addr1 = a1;
        #1;
        if (r0 && r1)  g = ref_prio;
        else if (r0)   g = 0;
        else if (r1)   g = 1;
        else           g = -1;
        if (g >= 0) ref_prio = 1 - g;
        chk("run_gnt0", 32'(gnt0), 32'(g == 0));
        chk("run_gnt1", 32'(gnt1), 32'(g == 1));
        chk("run_rd_en", 32'(lut_rd_en), 32'(g >= 0));
        chk("run_lut_run", 32'(lut_run), 32'd1);
        chk("run_loaded", 32'(loaded), 32'd1);
        chk("run_load_count", 32'(load_count), 32'(DEPTH));
        chk("run_cfg_ready", 32'(cfg_ready), 32'd0);
        chk("run_wr_en", 32'(lut_wr_en), 32'd0);
        if (g >= 0) begin
            int a;
            a = (g == 0) ? int'(a0) : int'(a1);
            chk("run_rd_addr", 32'(lut_rd_addr), 32'(a));
            sb_q.push_back('{id: g, data: ref_words[a]});
        end
    endtask

    // Random requests, each held with its address until granted.
    task automatic run_random(input int n);
        logic          p0, p1;
        logic [AW-1:0] a0, a1;
        int            g;
        p0 = 1'b0; p1 = 1'b0; a0 = '0; a1 = '0;
        for (int i = 0; i < n; i++) begin
            if (!p0) begin p0 = ($urandom_range(0, 2) != 0); a0 = AW'($urandom); end
            if (!p1) begin p1 = ($urandom_range(0, 2) != 0); a1 = AW'($urandom); end
            step_run(p0, p1, a0, a1, g);
            if (g == 0) p0 = 1'b0;
            if (g == 1) p1 = 1'b0;
        end
    endtask

    // Reload pulse with a word and optionally a request present.
    task automatic reload_cycle(input logic r0);
        @(negedge clk);
        cfg_reload = 1'b1; cfg_valid = 1'b1; cfg_data = DW'($urandom);
        req0 = r0; req1 = 1'b0; addr0 = AW'(9);
        #1;
        chk("reload_ready", 32'(cfg_ready), 32'd0);
        chk("reload_wr_en", 32'(lut_wr_en), 32'd0);
        chk("reload_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        chk("reload_rd_en", 32'(lut_rd_en), 32'd0);
        chk("reload_count", 32'(load_count), 32'(ref_words.size()));
    endtask

    // Assert reset mid-cycle and check that everything clears at once.
    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        cfg_valid = 1'b0; cfg_reload = 1'b0; req0 = 1'b0; req1 = 1'b0;
        sb_q.delete();
        ref_words.delete();
        ref_prio = 0;
        #1;
        chk("rst_loaded", 32'(loaded), 32'd0);
        chk("rst_lut_run", 32'(lut_run), 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("rst_load_count", 32'(load_count), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int g;
        reset = 1'b1;
        cfg_data = '0; cfg_valid = 1'b0; cfg_reload = 1'b0;
        req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
        ref_prio = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_loaded", 32'(loaded), 32'd0);
        chk("rst_lut_run", 32'(lut_run), 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("rst_load_count", 32'(load_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Flush, full load of value=index with requests held during LOAD
        expect_flush(1'b0);
        load_words(DEPTH, 1'b1, 1'b1);
        step_run(1'b1, 1'b0, AW'(3), AW'(4), g);     // first RUN cycle grants

        // Directed reads
        step_run(1'b1, 1'b0, AW'(5), AW'(0), g);
        step_run(1'b0, 1'b0, AW'(0), AW'(0), g);
        step_run(1'b0, 1'b1, AW'(7), AW'(7), g);     // leaves requester 0 preferred
        repeat (4) step_run(1'b1, 1'b1, AW'(10), AW'(20), g);
        step_run(1'b0, 1'b0, AW'(0), AW'(0), g);

        run_random(300);

        // Reload from RUN right after a grant; reload inside FLUSH is ignored
        step_run(1'b1, 1'b0, AW'(33), AW'(0), g);
        reload_cycle(1'b1);
        expect_flush(1'b1);

        // Partial load then reload, then a full random load
        load_words(100, 1'b0, 1'b0);
        reload_cycle(1'b0);
        expect_flush(1'b0);
        load_words(DEPTH, 1'b0, 1'b0);
        step_run(1'b1, 1'b0, AW'(0), AW'(0), g);     // table[0] = first new word
        run_random(200);

        // Reset in RUN one cycle after a grant
        step_run(1'b1, 1'b0, AW'(7), AW'(0), g);
        apply_reset();
        expect_flush(1'b0);
        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
